// File: rtl/register_uart_defs.sv
// Shared definitions for register_uart: register offsets, STATUS bit positions and FSM state encodings.
package register_uart_defs;

  localparam logic [11:0] OFF_DATA    = 12'd0;
  localparam logic [11:0] OFF_STATUS  = 12'd1;
  localparam logic [11:0] OFF_DIVISOR = 12'd2;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_IDLE     = 1;
  localparam int ST_RX_VALID    = 2;
  localparam int ST_RX_OVERRUN  = 3;
  localparam int ST_TX_OVERFLOW = 4;
  localparam int ST_LOOPBACK    = 5;

  localparam logic [15:0] MIN_DIVISOR = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  // Divisors below 4 leave no room for a meaningful half-bit sample point.
  function automatic logic [15:0] clamp_divisor(input logic [15:0] value);
    return (value < MIN_DIVISOR) ? MIN_DIVISOR : value;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead byte FIFO for the UART transmitter; push while full is dropped
// unless a pop happens on the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  input  logic       i_pop,
  output logic [7:0] o_pop_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic [7:0]  r_mem [DEPTH];
  logic        w_do_push, w_do_pop;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/register_uart.sv
// Polled 8N1 UART on the ulisp register bus: DATA/STATUS/DIVISOR at BASE_INDEX+0..2.
// Define UART_LOOPBACK_EN to feed the receiver from uart_tx instead of uart_rx.
module register_uart
  import register_uart_defs::*;
#(
  parameter int BASE_INDEX      = 0,
  parameter int TX_FIFO_DEPTH   = 8,
  parameter int DEFAULT_DIVISOR = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam logic [11:0] IDX_DATA    = 12'(BASE_INDEX) + OFF_DATA;
  localparam logic [11:0] IDX_STATUS  = 12'(BASE_INDEX) + OFF_STATUS;
  localparam logic [11:0] IDX_DIVISOR = 12'(BASE_INDEX) + OFF_DIVISOR;

  logic [15:0] r_divisor;
  logic [7:0]  r_rx_byte;
  logic        r_rx_valid, r_rx_overrun, r_tx_overflow;

  logic        w_data_wr, w_data_rd, w_status_rd, w_div_wr, w_loopback;
  logic        w_fifo_pop, w_fifo_full, w_fifo_empty;
  logic [7:0]  w_fifo_data;

  tx_state_t   r_tx_state, w_tx_state_n;
  logic [15:0] r_tx_cnt, w_tx_cnt_n, r_tx_div, w_tx_div_n;
  logic [7:0]  r_tx_shift, w_tx_shift_n;
  logic [2:0]  r_tx_bit, w_tx_bit_n;
  logic        r_uart_tx, w_uart_tx_n, w_tx_load;

  rx_state_t   r_rx_state, w_rx_state_n;
  logic [15:0] r_rx_cnt, w_rx_cnt_n, r_rx_div, w_rx_div_n;
  logic [7:0]  r_rx_shift, w_rx_shift_n;
  logic [2:0]  r_rx_bit, w_rx_bit_n;
  logic [1:0]  r_rx_sync;
  logic        r_rx_prev, w_rx_pin, w_rx_s, w_rx_done;

  assign w_data_wr   = register_write && (register_index == IDX_DATA);
  assign w_div_wr    = register_write && (register_index == IDX_DIVISOR);
  assign w_data_rd   = register_read  && (register_index == IDX_DATA);
  assign w_status_rd = register_read  && (register_index == IDX_STATUS);

`ifdef UART_LOOPBACK_EN
  assign w_rx_pin   = r_uart_tx;
  assign w_loopback = 1'b1;
`else
  assign w_rx_pin   = uart_rx;
  assign w_loopback = 1'b0;
`endif

  uart_tx_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_data_wr),
    .i_push_data(register_write_value[7:0]),
    .i_pop      (w_fifo_pop),
    .o_pop_data (w_fifo_data),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  // NOTE: every combinational output gets a default first so no path through the case infers a latch.
  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n   = r_tx_cnt;
    w_tx_div_n   = r_tx_div;
    w_tx_shift_n = r_tx_shift;
    w_tx_bit_n   = r_tx_bit;
    w_tx_load    = 1'b0;
    w_fifo_pop   = 1'b0;
    unique case (r_tx_state)
      TX_IDLE:  w_tx_load = !w_fifo_empty;
      TX_START: begin
        w_tx_cnt_n = r_tx_cnt - 16'd1;
        if (r_tx_cnt == '0) begin
          w_tx_cnt_n   = r_tx_div - 16'd1;
          w_tx_bit_n   = '0;
          w_tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        w_tx_cnt_n = r_tx_cnt - 16'd1;
        if (r_tx_cnt == '0) begin
          w_tx_cnt_n = r_tx_div - 16'd1;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_n = TX_STOP;
          end else begin
            w_tx_shift_n = r_tx_shift >> 1;
            w_tx_bit_n   = r_tx_bit + 3'd1;
          end
        end
      end
      TX_STOP: begin
        w_tx_cnt_n = r_tx_cnt - 16'd1;
        if (r_tx_cnt == '0) begin
          w_tx_state_n = TX_IDLE;
          w_tx_load    = !w_fifo_empty;
        end
      end
    endcase
    // The divisor is captured per frame so a mid-frame DIVISOR write waits for the next byte.
    if (w_tx_load) begin
      w_fifo_pop   = 1'b1;
      w_tx_div_n   = r_divisor;
      w_tx_cnt_n   = r_divisor - 16'd1;
      w_tx_shift_n = w_fifo_data;
      w_tx_state_n = TX_START;
    end
    unique case (w_tx_state_n)
      TX_START: w_uart_tx_n = 1'b0;
      TX_DATA:  w_uart_tx_n = w_tx_shift_n[0];
      default:  w_uart_tx_n = 1'b1;
    endcase
  end

  assign w_rx_s = r_rx_sync[1];

  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_cnt_n   = r_rx_cnt;
    w_rx_div_n   = r_rx_div;
    w_rx_shift_n = r_rx_shift;
    w_rx_bit_n   = r_rx_bit;
    w_rx_done    = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: begin
        if (!w_rx_s && r_rx_prev) begin
          w_rx_div_n   = r_divisor;
          w_rx_cnt_n   = (r_divisor >> 1) - 16'd1;
          w_rx_state_n = RX_START;
        end
      end
      RX_START: begin
        w_rx_cnt_n = r_rx_cnt - 16'd1;
        if (r_rx_cnt == '0) begin
          w_rx_cnt_n   = r_rx_div - 16'd1;
          w_rx_bit_n   = '0;
          w_rx_state_n = w_rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        w_rx_cnt_n = r_rx_cnt - 16'd1;
        if (r_rx_cnt == '0) begin
          w_rx_cnt_n   = r_rx_div - 16'd1;
          w_rx_shift_n = {w_rx_s, r_rx_shift[7:1]};
          w_rx_bit_n   = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        w_rx_cnt_n = r_rx_cnt - 16'd1;
        if (r_rx_cnt == '0) begin
          w_rx_done    = w_rx_s;
          w_rx_state_n = w_rx_s ? RX_IDLE : RX_WAIT_IDLE;
        end
      end
      RX_WAIT_IDLE: if (w_rx_s) w_rx_state_n = RX_IDLE;
      default:      w_rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_div   <= 16'(DEFAULT_DIVISOR);
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_uart_tx  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_div   <= 16'(DEFAULT_DIVISOR);
      r_rx_shift <= '0;
      r_rx_bit   <= '0;
      r_rx_sync  <= 2'b11;
      r_rx_prev  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_cnt   <= w_tx_cnt_n;
      r_tx_div   <= w_tx_div_n;
      r_tx_shift <= w_tx_shift_n;
      r_tx_bit   <= w_tx_bit_n;
      r_uart_tx  <= w_uart_tx_n;
      r_rx_state <= w_rx_state_n;
      r_rx_cnt   <= w_rx_cnt_n;
      r_rx_div   <= w_rx_div_n;
      r_rx_shift <= w_rx_shift_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_sync  <= {r_rx_sync[0], w_rx_pin};
      r_rx_prev  <= w_rx_s;
    end
  end

  // Sticky flags: a new event on the same edge as the STATUS read wins so it is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_divisor     <= 16'(DEFAULT_DIVISOR);
      r_rx_byte     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_overflow <= 1'b0;
    end else begin
      if (w_div_wr) r_divisor <= clamp_divisor(register_write_value);
      if (w_rx_done && (!r_rx_valid || w_data_rd)) begin
        r_rx_byte  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_data_rd) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_done && r_rx_valid && !w_data_rd) r_rx_overrun <= 1'b1;
      else if (w_status_rd)                      r_rx_overrun <= 1'b0;
      if (w_data_wr && w_fifo_full && !w_fifo_pop) r_tx_overflow <= 1'b1;
      else if (w_status_rd)                        r_tx_overflow <= 1'b0;
    end
  end

  always_comb begin
    register_read_value = '0;
    if (register_index == IDX_DATA) begin
      register_read_value = {8'h00, r_rx_byte};
    end else if (register_index == IDX_STATUS) begin
      register_read_value[ST_TX_FULL]     = w_fifo_full;
      register_read_value[ST_TX_IDLE]     = w_fifo_empty && (r_tx_state == TX_IDLE);
      register_read_value[ST_RX_VALID]    = r_rx_valid;
      register_read_value[ST_RX_OVERRUN]  = r_rx_overrun;
      register_read_value[ST_TX_OVERFLOW] = r_tx_overflow;
      register_read_value[ST_LOOPBACK]    = w_loopback;
    end else if (register_index == IDX_DIVISOR) begin
      register_read_value = r_divisor;
    end
  end

  assign uart_tx = r_uart_tx;

endmodule

// File: tb/tb_register_uart.sv
// Scoreboarded bench for register_uart: a serial-line monitor decodes uart_tx and checks it
// against bytes queued by the stimulus; register reads are checked against spec-level expectations.
module tb_register_uart;

  localparam logic [11:0] A_DATA = 12'd0, A_STATUS = 12'd1, A_DIV = 12'd2;
  localparam int DEPTH = 8;
`ifdef UART_LOOPBACK_EN
  localparam logic LB = 1'b1;
`else
  localparam logic LB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] register_index;
  logic        register_read, register_write;
  logic [15:0] register_write_value, register_read_value;
  logic        uart_tx, uart_rx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  int   mon_div  = 16;
  logic mon_en   = 1'b1;
  logic mon_b2b  = 1'b0;
  int   mon_prev = -1;

  register_uart #(.BASE_INDEX(0), .TX_FIFO_DEPTH(DEPTH), .DEFAULT_DIVISOR(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .register_index      (register_index),
    .register_read       (register_read),
    .register_write      (register_write),
    .register_write_value(register_write_value),
    .register_read_value (register_read_value),
    .uart_tx             (uart_tx),
    .uart_rx             (uart_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] st(input logic full, idle, valid, ovr, ovf);
    return {10'b0, LB, ovf, ovr, valid, idle, full};
  endfunction

  task automatic bus_write(input logic [11:0] idx, input logic [15:0] val);
    @(negedge clk);
    register_index = idx; register_write_value = val; register_write = 1'b1;
    @(posedge clk); #1;
    register_write = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [11:0] idx, input logic [15:0] exp);
    @(negedge clk);
    register_index = idx; register_read = 1'b1;
    #1 check(name, register_read_value, exp);
    @(posedge clk); #1;
    register_read = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input int div, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (div) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (div) @(negedge clk);
  endtask

  task automatic wait_tx_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("tx_drain", exp_q.size(), 0);
    repeat (mon_div + 2) @(negedge clk);
  endtask

  // Serial-line monitor: decode each 8N1 frame at bit centres and score it.
  logic [7:0] mon_byte;
  logic       mon_start, mon_stop;
  int         mon_s, mon_d;
  always begin : tx_monitor
    @(negedge clk);
    if (uart_tx === 1'b0) begin
      mon_s = cyc;
      mon_d = mon_div;
      repeat (mon_d / 2) @(negedge clk);
      mon_start = uart_tx;
      for (int i = 0; i < 8; i++) begin
        repeat (mon_d) @(negedge clk);
        mon_byte[i] = uart_tx;
      end
      repeat (mon_d) @(negedge clk);
      mon_stop = uart_tx;
      if (mon_en) begin
        check("tx_start_bit", mon_start, 1'b0);
        check("tx_stop_bit", mon_stop, 1'b1);
        if (exp_q.size() == 0) check("tx_unexpected_byte", exp_q.size(), 1);
        else check("tx_byte", mon_byte, exp_q.pop_front());
        if (mon_b2b && mon_prev >= 0) check("tx_frame_gap", mon_s - mon_prev, 10 * mon_d);
        mon_prev = mon_s;
      end
    end
  end

  logic [15:0] div_in  [5] = '{16'd0, 16'd3, 16'd4, 16'd5, 16'h1234};
  logic [15:0] div_exp [5] = '{16'd4, 16'd4, 16'd4, 16'd5, 16'h1234};
  logic [7:0]  rb;

  initial begin
    reset = 1'b1; register_index = '0; register_read = 1'b0; register_write = 1'b0;
    register_write_value = '0; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_uart_tx", uart_tx, 1'b1);
    read_check("rst_status", A_STATUS, st(0, 1, 0, 0, 0));
    read_check("rst_divisor", A_DIV, 16'd16);
    read_check("rst_data", A_DATA, 16'h0000);

    bus_write(12'd3, 16'hFFFF);
    read_check("unmapped_3", 12'd3, 16'h0000);
    read_check("unmapped_fff", 12'hFFF, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      bus_write(A_DIV, div_in[i]);
      read_check("divisor_clamp", A_DIV, div_exp[i]);
    end

`ifndef UART_LOOPBACK_EN
    // Single character at divisor 4: two-cycle latency, 4-clock start bit, LSB first.
    bus_write(A_DIV, 16'd4);
    mon_div = 4;
    exp_q.push_back(8'h41);
    bus_write(A_DATA, 16'h0041);
    @(negedge clk) check("tx_latency_pre", uart_tx, 1'b1);
    for (int i = 0; i < 4; i++) @(negedge clk) check("tx_start_len", uart_tx, 1'b0);
    @(negedge clk) check("tx_bit0", uart_tx, 1'b1);
    wait_tx_drain();
    read_check("tx_idle_after", A_STATUS, st(0, 1, 0, 0, 0));

    // Burst of DEPTH+2 writes: one leaves at once, DEPTH are buffered, the last is dropped.
    mon_b2b = 1'b1; mon_prev = -1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH + 1) exp_q.push_back(8'(8'h30 + i));
      bus_write(A_DATA, 16'(16'h30 + i));
    end
    read_check("status_overflow", A_STATUS, st(1, 0, 0, 0, 1));
    read_check("status_overflow_clr", A_STATUS, st(1, 0, 0, 0, 0));
    wait_tx_drain();
    mon_b2b = 1'b0;
    read_check("burst_idle", A_STATUS, st(0, 1, 0, 0, 0));

    // Receive path at divisor 8.
    bus_write(A_DIV, 16'd8);
    mon_div = 8;
    send_rx(8'h5A, 8, 1'b1);
    repeat (4) @(negedge clk);
    read_check("rx_valid_set", A_STATUS, st(0, 1, 1, 0, 0));
    read_check("rx_data_5a", A_DATA, 16'h005A);
    read_check("rx_valid_clr", A_STATUS, st(0, 1, 0, 0, 0));

    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      send_rx(rb, 8, 1'b1);
      repeat (4) @(negedge clk);
      read_check("rx_rand_status", A_STATUS, st(0, 1, 1, 0, 0));
      read_check("rx_rand_data", A_DATA, {8'h00, rb});
    end

    send_rx(8'h11, 8, 1'b1);
    send_rx(8'h22, 8, 1'b1);
    repeat (4) @(negedge clk);
    read_check("rx_overrun_set", A_STATUS, st(0, 1, 1, 1, 0));
    read_check("rx_overrun_clr", A_STATUS, st(0, 1, 1, 0, 0));
    read_check("rx_keep_old", A_DATA, 16'h0011);
    read_check("rx_after_overrun", A_STATUS, st(0, 1, 0, 0, 0));

    send_rx(8'h33, 8, 1'b0);
    repeat (24) @(negedge clk);
    read_check("rx_framing", A_STATUS, st(0, 1, 0, 0, 0));
    uart_rx = 1'b1;
    repeat (16) @(negedge clk);
    send_rx(8'h66, 8, 1'b1);
    repeat (4) @(negedge clk);
    read_check("rx_rearm_status", A_STATUS, st(0, 1, 1, 0, 0));
    read_check("rx_rearm_data", A_DATA, 16'h0066);

    @(negedge clk) uart_rx = 1'b0;
    @(negedge clk) uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    read_check("rx_glitch", A_STATUS, st(0, 1, 0, 0, 0));

    // Random transmit burst at divisor 8.
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(rb);
      bus_write(A_DATA, {8'h00, rb});
    end
    wait_tx_drain();
    read_check("rand_tx_idle", A_STATUS, st(0, 1, 0, 0, 0));
`endif

    // Reset in the middle of a frame.
    mon_en = 1'b0;
    bus_write(A_DATA, 16'h0055);
    repeat (3) @(negedge clk);
    check("pre_reset_tx_low", uart_tx, 1'b0);
    reset = 1'b1;
    @(negedge clk) check("reset_tx_high", uart_tx, 1'b1);
    reset = 1'b0;
    read_check("reset_status", A_STATUS, st(0, 1, 0, 0, 0));
    read_check("reset_divisor", A_DIV, 16'd16);
    repeat (200) @(negedge clk);
    check("reset_tx_stays_idle", uart_tx, 1'b1);
    mon_div = 16;
    mon_en  = 1'b1;

`ifdef UART_LOOPBACK_EN
    exp_q.push_back(8'hA5);
    bus_write(A_DATA, 16'h00A5);
    wait_tx_drain();
    read_check("lb_status", A_STATUS, st(0, 1, 1, 0, 0));
    read_check("lb_data", A_DATA, 16'h00A5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
